// File: rtl/ahb_ldst_master.sv
// ahb_ldst_master
//   Load/store AHB-Lite master. It accepts one core memory request at a time
//   and issues a single non-pipelined transfer for it. Load data is
//   byte-lane extracted and then sign- or zero-extended. A misaligned word
//   load is rotated, which gives ARMv4 LDR behaviour. The block reports a
//   bus ERROR and rejects a misaligned halfword access.
// Ports
//   clk, rst        : core clock (also HCLK), synchronous active-high reset
//   req_*           : request from decode (valid/ready handshake)
//   H*              : AHB-Lite master signals (HBURST/HPROT constant)
//   ld_valid/id/data: load writeback; the ld_valid pulse qualifies id/data
//   done, bus_err, align_fault : completion/exception pulses, one cycle each
module ahb_ldst_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd_id,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        ld_valid,
  output logic [4:0]  ld_id,
  output logic [31:0] ld_data,
  output logic        done,
  output logic        bus_err,
  output logic        align_fault
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  state_t      r_state;
  logic        r_wr;
  logic        r_sgn;
  logic [1:0]  r_size;
  logic [1:0]  r_alo;     // original addr[1:0], used for lane select
  logic [4:0]  r_id;
  logic [31:0] r_wrep;    // store data already replicated across lanes

  logic [1:0]  w_size;
  logic [31:0] w_haddr;
  logic [31:0] w_wrep;
  logic [31:0] w_ld;
  logic        w_misalign;

  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0001;
  // Comes only from the state register (and reset). It never depends on the bus.
  assign req_ready = (r_state == S_IDLE) && !rst;

  // Request-side decode. Size 11 is handled as a word access.
  always_comb begin
    w_size     = (req_size == 2'b11) ? 2'b10 : req_size;
    w_misalign = (w_size == 2'b01) && req_addr[0];
    w_haddr    = req_addr;
    w_wrep     = req_wdata;
    case (w_size)
      2'b00: w_wrep = {4{req_wdata[7:0]}};
      2'b01: begin
        w_wrep     = {2{req_wdata[15:0]}};
        w_haddr[0] = 1'b0;
      end
      default: w_haddr[1:0] = 2'b00;
    endcase
  end

  // Load extraction from HRDATA. Words are rotated right by the byte offset.
  always_comb begin
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [63:0] rot;
    sh_b = HRDATA >> {r_alo, 3'b000};
    sh_h = HRDATA >> {r_alo[1], 4'b0000};
    rot  = {HRDATA, HRDATA} >> {r_alo, 3'b000};
    case (r_size)
      2'b00:   w_ld = r_sgn ? {{24{sh_b[7]}}, sh_b[7:0]}   : {24'b0, sh_b[7:0]};
      2'b01:   w_ld = r_sgn ? {{16{sh_h[15]}}, sh_h[15:0]} : {16'b0, sh_h[15:0]};
      default: w_ld = rot[31:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr        <= 1'b0;
      r_sgn       <= 1'b0;
      r_size      <= 2'b00;
      r_alo       <= 2'b00;
      r_id        <= 5'd0;
      r_wrep      <= 32'd0;
      HADDR       <= 32'd0;
      HTRANS      <= HT_IDLE;
      HWRITE      <= 1'b0;
      HSIZE       <= 3'b000;
      HWDATA      <= 32'd0;
      ld_valid    <= 1'b0;
      ld_id       <= 5'd0;
      ld_data     <= 32'd0;
      done        <= 1'b0;
      bus_err     <= 1'b0;
      align_fault <= 1'b0;
    end else begin
      // Every pulse output lasts a single cycle by default.
      ld_valid    <= 1'b0;
      done        <= 1'b0;
      bus_err     <= 1'b0;
      align_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_misalign) begin
              align_fault <= 1'b1;
              done        <= 1'b1;
            end else begin
              r_wr    <= req_wr;
              r_sgn   <= req_signed;
              r_size  <= w_size;
              r_alo   <= req_addr[1:0];
              r_id    <= req_rd_id;
              r_wrep  <= w_wrep;
              HADDR   <= w_haddr;
              HTRANS  <= HT_NONSEQ;
              HWRITE  <= req_wr;
              HSIZE   <= {1'b0, w_size};
              r_state <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            HTRANS  <= HT_IDLE;
            HWDATA  <= r_wrep;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (HRESP) begin
            // A slave that gives a single-cycle ERROR (HREADY=1) still completes as an error.
            if (HREADY) begin
              bus_err <= 1'b1;
              done    <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_ERR;
            end
          end else if (HREADY) begin
            done    <= 1'b1;
            r_state <= S_IDLE;
            if (!r_wr) begin
              ld_valid <= 1'b1;
              ld_id    <= r_id;
              ld_data  <= w_ld;
            end
          end
        end
        S_ERR: begin
          if (HREADY) begin
            bus_err <= 1'b1;
            done    <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_ldst_master.sv
module tb_ahb_ldst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd_id;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        ld_valid, done, bus_err, align_fault;
  logic [4:0]  ld_id;
  logic [31:0] ld_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ahb_ldst_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd_id(req_rd_id),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .ld_valid(ld_valid), .ld_id(ld_id), .ld_data(ld_data),
    .done(done), .bus_err(bus_err), .align_fault(align_fault)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  id;
    logic [31:0] rdata;
    logic [31:0] e_haddr;
    logic [2:0]  e_hsize;
    logic [31:0] e_hwdata;
    logic [31:0] e_ld;
  } tv_t;

  tv_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input tv_t v);
    req_valid  = 1'b1;
    req_wr     = v.wr;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_rd_id  = v.id;
  endtask

  // A single transfer with aw address-phase and dw data-phase wait states, and an OKAY response
  task automatic run(input tv_t v, input int aw, input int dw);
    issue(v);
    chk("rdy_T0", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("htrans_nonseq", 32'(HTRANS), 32'd2);
    chk("haddr", HADDR, v.e_haddr);
    chk("hsize", 32'(HSIZE), 32'(v.e_hsize));
    chk("hwrite", 32'(HWRITE), 32'(v.wr));
    HREADY = 1'b0;
    repeat (aw) begin
      step();
      chk("addr_hold_htrans", 32'(HTRANS), 32'd2);
      chk("addr_hold_haddr", HADDR, v.e_haddr);
    end
    HREADY = 1'b1;
    step();
    chk("data_htrans_idle", 32'(HTRANS), 32'd0);
    chk("data_rdy_low", 32'(req_ready), 32'd0);
    if (v.wr) chk("hwdata", HWDATA, v.e_hwdata);
    HREADY = 1'b0;
    repeat (dw) begin
      step();
      chk("wait_no_done", 32'(done), 32'd0);
      if (v.wr) chk("hwdata_hold", HWDATA, v.e_hwdata);
    end
    HREADY = 1'b1;
    HRDATA = v.rdata;
    step();
    HRDATA = 32'h0;
    chk("done", 32'(done), 32'd1);
    chk("ld_valid", 32'(ld_valid), 32'(!v.wr));
    chk("bus_err_low", 32'(bus_err), 32'd0);
    chk("rdy_at_done", 32'(req_ready), 32'd1);
    if (!v.wr) begin
      chk("ld_data", ld_data, v.e_ld);
      chk("ld_id", 32'(ld_id), 32'(v.id));
    end
    step();
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("ld_valid_pulse_end", 32'(ld_valid), 32'd0);
  endtask

  initial begin
    tv_t t;
    //        wr   sz     sg   addr          wdata         id     rdata         haddr         hsz     hwdata        ld
    vecs[0] = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        5'd7,  32'h11223344, 32'h100, 3'b010, 32'h0,        32'h11223344};
    vecs[1] = '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        5'd3,  32'h80FF0000, 32'h103, 3'b000, 32'h0,        32'hFFFFFF80};
    vecs[2] = '{1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        5'd4,  32'h80FF0000, 32'h103, 3'b000, 32'h0,        32'h00000080};
    vecs[3] = '{1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        5'd9,  32'h80011234, 32'h102, 3'b001, 32'h0,        32'hFFFF8001};
    vecs[4] = '{1'b0, 2'b10, 1'b0, 32'h301, 32'h0,        5'd12, 32'hDDCCBBAA, 32'h300, 3'b010, 32'h0,        32'hAADDCCBB};
    vecs[5] = '{1'b1, 2'b01, 1'b0, 32'h402, 32'h1234ABCD, 5'd0,  32'h0,        32'h402, 3'b001, 32'hABCDABCD, 32'h0};
    vecs[6] = '{1'b1, 2'b10, 1'b0, 32'h503, 32'hCAFEF00D, 5'd0,  32'h0,        32'h500, 3'b010, 32'hCAFEF00D, 32'h0};
    vecs[7] = '{1'b0, 2'b11, 1'b0, 32'h600, 32'h0,        5'd31, 32'h01020304, 32'h600, 3'b010, 32'h0,        32'h01020304};
    vecs[8] = '{1'b0, 2'b01, 1'b1, 32'h100, 32'h0,        5'd1,  32'h1234F00D, 32'h100, 3'b001, 32'h0,        32'hFFFFF00D};
    vecs[9] = '{1'b1, 2'b00, 1'b0, 32'h201, 32'h000000A5, 5'd0,  32'h0,        32'h201, 3'b000, 32'hA5A5A5A5, 32'h0};

    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd_id = 5'd0;
    HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    step(); step();
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_pulses", {28'd0, ld_valid, done, bus_err, align_fault}, 32'h0);
    chk("rst_ld_data", ld_data, 32'h0);
    chk("hburst", 32'(HBURST), 32'd0);
    chk("hprot", 32'(HPROT), 32'd1);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Zero-wait table sweep
    for (int i = 0; i < 9; i++) run(vecs[i], 0, 0);

    // Byte store with 2 data-phase wait states, then a load with an address wait state
    run(vecs[9], 0, 2);
    run(vecs[3], 1, 0);

    // Misaligned halfword -> align fault, no bus transfer
    t = vecs[3]; t.addr = 32'h301;
    issue(t);
    step();
    req_valid = 1'b0;
    chk("af_pulse", 32'(align_fault), 32'd1);
    chk("af_done", 32'(done), 32'd1);
    chk("af_htrans", 32'(HTRANS), 32'd0);
    chk("af_ready", 32'(req_ready), 32'd1);
    step();
    chk("af_end", 32'(align_fault), 32'd0);
    chk("af_htrans2", 32'(HTRANS), 32'd0);

    // Two-cycle ERROR response on a load
    issue(vecs[0]);
    step();
    req_valid = 1'b0;
    HREADY = 1'b1;
    step();                       // data phase
    HREADY = 1'b0; HRESP = 1'b1;
    step();                       // first ERROR cycle sampled
    chk("err_no_done_yet", 32'(done), 32'd0);
    HREADY = 1'b1;
    step();                       // second ERROR cycle sampled
    HRESP = 1'b0;
    chk("err_bus_err", 32'(bus_err), 32'd1);
    chk("err_done", 32'(done), 32'd1);
    chk("err_no_ld", 32'(ld_valid), 32'd0);
    chk("err_ready", 32'(req_ready), 32'd1);
    step();
    chk("err_pulse_end", 32'(bus_err), 32'd0);
    run(vecs[4], 0, 0);           // next request still accepted

    // Reset during address phase with HREADY low
    issue(vecs[6]);
    step();
    req_valid = 1'b0;
    HREADY = 1'b0;
    chk("pre_rst_nonseq", 32'(HTRANS), 32'd2);
    rst = 1'b1;
    step();
    chk("mid_rst_htrans", 32'(HTRANS), 32'd0);
    chk("mid_rst_haddr", HADDR, 32'h0);
    chk("mid_rst_hwrite", 32'(HWRITE), 32'd0);
    chk("mid_rst_pulses", {28'd0, ld_valid, done, bus_err, align_fault}, 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    HREADY = 1'b1;
    step();
    chk("post_rst_no_done", 32'(done), 32'd0);
    chk("post_rst_htrans", 32'(HTRANS), 32'd0);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    run(vecs[1], 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
